// File: rtl/register_tree_ctrl.sv
// Max-heap priority queue sequencer over a register tree, re-settled by alternating even/odd-level compare passes.
// Op accepted at t -> busy t+1..t+k, IDLE at t+k+1; ready/valid held low while settling, requests then are ignored.
module register_tree_ctrl #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int TREE_LEVELS = 3,
  localparam int NODES       = (1 << TREE_LEVELS) - 1,
  localparam int CW          = $clog2(NODES + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enq_valid,
  input  logic [DATA_WIDTH-1:0] i_enq_data,
  output logic                  o_enq_ready,
  input  logic                  i_deq_req,
  output logic                  o_deq_valid,
  output logic [DATA_WIDTH-1:0] o_deq_data,
  output logic [CW-1:0]         o_count,
  output logic                  o_busy
);

  localparam int PARENTS = (NODES - 1) / 2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SORT = 1'b1;

  logic [0:0]            state;
  logic                  phase;
  logic                  clean;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] node [NODES];
  logic [DATA_WIDTH-1:0] nxt  [NODES];
  logic                  swapped;
  logic                  enq_fire;
  logic                  deq_fire;

  function automatic int node_level(int n);
    int l = 0;
    for (int i = 1; i < 32; i++) begin
      if (((n + 1) >> i) != 0) l = i;
    end
    return l;
  endfunction

  assign o_deq_valid = (state == IDLE) && (count != '0);
  assign deq_fire    = i_deq_req && o_deq_valid;
  assign o_enq_ready = (state == IDLE) && ((count < CW'(NODES)) || deq_fire);
  assign enq_fire    = i_enq_valid && o_enq_ready;
  assign o_deq_data  = node[0];
  assign o_count     = count;
  assign o_busy      = (state == SORT);

  // Parents on the same level parity own disjoint triples, so all reads use the current array.
  always_comb begin
    nxt     = node;
    swapped = 1'b0;
    for (int p = 0; p < PARENTS; p++) begin
      if (((node_level(p) % 2) == 1) == phase) begin
        if (node[2*p+1] > node[2*p+2]) begin
          if (node[p] < node[2*p+1]) begin
            nxt[p]     = node[2*p+1];
            nxt[2*p+1] = node[p];
            swapped    = 1'b1;
          end
        end else if (node[p] < node[2*p+2]) begin
          nxt[p]     = node[2*p+2];
          nxt[2*p+2] = node[p];
          swapped    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      phase <= 1'b0;
      clean <= 1'b0;
      count <= '0;
      for (int i = 0; i < NODES; i++) node[i] <= '0;
    end else if (state == IDLE) begin
      if (enq_fire && deq_fire) begin
        node[0] <= i_enq_data;
        state   <= SORT;
      end else if (enq_fire) begin
        node[count] <= i_enq_data;
        count       <= count + 1'b1;
        state       <= SORT;
      end else if (deq_fire) begin
        // Last write wins, so a single-entry dequeue leaves the root empty.
        node[0]              <= node[count - 1'b1];
        node[count - 1'b1]   <= '0;
        count                <= count - 1'b1;
        state                <= SORT;
      end
    end else begin
      node  <= nxt;
      phase <= ~phase;
      if (swapped) begin
        clean <= 1'b0;
      end else if (clean) begin
        clean <= 1'b0;
        phase <= 1'b0;
        state <= IDLE;
      end else begin
        clean <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_register_tree_ctrl.sv
// Directed bench for register_tree_ctrl at TREE_LEVELS=3, DATA_WIDTH=32.
module tb_register_tree_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_enq_valid;
  logic [31:0] i_enq_data;
  logic        o_enq_ready;
  logic        i_deq_req;
  logic        o_deq_valid;
  logic [31:0] o_deq_data;
  logic [2:0]  o_count;
  logic        o_busy;

  int vectors    = 0;
  int miscompares = 0;
  logic [31:0] got;

  register_tree_ctrl #(.DATA_WIDTH(32), .TREE_LEVELS(3)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_enq_valid (i_enq_valid),
    .i_enq_data  (i_enq_data),
    .o_enq_ready (o_enq_ready),
    .i_deq_req   (i_deq_req),
    .o_deq_valid (o_deq_valid),
    .o_deq_data  (o_deq_data),
    .o_count     (o_count),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called #1 after the accepting edge; counts busy cycles until IDLE, bounded.
  task automatic settle(input int kmin);
    int k = 0;
    while (o_busy && k < 20) begin
      k++;
      @(posedge i_clk); #1;
    end
    chk("settle_k_range", {31'b0, (k >= kmin && k <= 8)}, 32'd1);
  endtask

  task automatic do_op(input logic ev, input logic [31:0] d, input logic dr,
                       output logic [31:0] root_before);
    @(negedge i_clk);
    i_enq_valid = ev;
    i_enq_data  = d;
    i_deq_req   = dr;
    root_before = o_deq_data;
    @(posedge i_clk); #1;
    i_enq_valid = 1'b0;
    i_deq_req   = 1'b0;
    settle(2);
  endtask

  task automatic enq(input logic [31:0] d);
    logic [31:0] unused_root;
    do_op(1'b1, d, 1'b0, unused_root);
  endtask

  task automatic deq(input string tag, input logic [31:0] exp);
    logic [31:0] r;
    do_op(1'b0, 32'd0, 1'b1, r);
    chk(tag, r, exp);
  endtask

  task automatic pulse_reset();
    @(negedge i_clk); i_rst = 1'b1;
    @(negedge i_clk); i_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_enq_valid = 1'b0; i_enq_data = '0; i_deq_req = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_count",     32'(o_count),     32'd0);
    chk("rst_enq_ready", 32'(o_enq_ready), 32'd1);
    chk("rst_deq_valid", 32'(o_deq_valid), 32'd0);
    chk("rst_deq_data",  o_deq_data,       32'd0);
    chk("rst_busy",      32'(o_busy),      32'd0);
    @(negedge i_clk); i_rst = 1'b0;

    // Ordering
    enq(5); enq(9); enq(3); enq(7);
    chk("order_count", 32'(o_count), 32'd4);
    chk("order_root",  o_deq_data,   32'd9);
    deq("order_deq0", 9);
    deq("order_deq1", 7);
    deq("order_deq2", 5);
    deq("order_deq3", 3);
    chk("order_empty_valid", 32'(o_deq_valid), 32'd0);
    chk("order_empty_count", 32'(o_count),     32'd0);

    // Full
    for (int v = 1; v <= 7; v++) enq(32'(v));
    chk("full_count",     32'(o_count),     32'd7);
    chk("full_enq_ready", 32'(o_enq_ready), 32'd0);
    chk("full_root",      o_deq_data,       32'd7);
    @(negedge i_clk); i_enq_valid = 1'b1; i_enq_data = 32'd8;
    @(posedge i_clk); #1; i_enq_valid = 1'b0;
    chk("full_enq8_busy",  32'(o_busy),  32'd0);
    chk("full_enq8_count", 32'(o_count), 32'd7);
    chk("full_enq8_root",  o_deq_data,   32'd7);

    // Replace when full
    do_op(1'b1, 32'd6, 1'b1, got);
    chk("full_repl_out",   got,          32'd7);
    chk("full_repl_count", 32'(o_count), 32'd7);
    chk("full_repl_root",  o_deq_data,   32'd6);

    // Replace on {9,7,5}
    pulse_reset();
    enq(9); enq(7); enq(5);
    do_op(1'b1, 32'd8, 1'b1, got);
    chk("repl_out",   got,          32'd9);
    chk("repl_count", 32'(o_count), 32'd3);
    chk("repl_root",  o_deq_data,   32'd8);
    deq("repl_deq0", 8);
    deq("repl_deq1", 7);
    deq("repl_deq2", 5);

    // Ties
    enq(4); enq(4); enq(4);
    deq("tie_deq0", 4);
    deq("tie_deq1", 4);
    deq("tie_deq2", 4);
    chk("tie_count", 32'(o_count), 32'd0);

    // Requests during SORT are ignored
    @(negedge i_clk); i_enq_valid = 1'b1; i_enq_data = 32'd2;
    @(posedge i_clk); #1;
    i_enq_data = 32'd11; i_deq_req = 1'b1;
    chk("busy_flag",      32'(o_busy),      32'd1);
    chk("busy_enq_ready", 32'(o_enq_ready), 32'd0);
    chk("busy_deq_valid", 32'(o_deq_valid), 32'd0);
    @(posedge i_clk); #1;
    i_enq_valid = 1'b0; i_deq_req = 1'b0;
    chk("busy_count_mid", 32'(o_count), 32'd1);
    settle(1);
    chk("busy_count", 32'(o_count), 32'd1);
    chk("busy_root",  o_deq_data,   32'd2);

    // Reset in the middle of a settle
    @(negedge i_clk); i_enq_valid = 1'b1; i_enq_data = 32'd3;
    @(posedge i_clk); #1; i_enq_valid = 1'b0;
    chk("mrst_pre_busy", 32'(o_busy), 32'd1);
    i_rst = 1'b1; #1;
    chk("mrst_count",     32'(o_count),     32'd0);
    chk("mrst_busy",      32'(o_busy),      32'd0);
    chk("mrst_enq_ready", 32'(o_enq_ready), 32'd1);
    chk("mrst_deq_valid", 32'(o_deq_valid), 32'd0);
    @(negedge i_clk); i_rst = 1'b0;
    enq(6);
    chk("mrst_root",  o_deq_data,   32'd6);
    chk("mrst_count1", 32'(o_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
